wave_sched: RTL and testbench



---
 rtl/wave_sched.sv | 126 ++++++++++++
 tb/tb_wave_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sched.sv
// rtl/wave_sched.sv - program-table sequencer that owns the sig_gen_1 wave_choise select
// Optional WAVE_SCHED_LOOP_EN: replay the program from entry 0 until a stop drains it.
module wave_sched #(
    parameter int         DEPTH       = 4,
    parameter int         DUR_W       = 8,
    parameter logic [1:0] IDLE_CHOICE = 2'b00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [1:0]               wr_choice,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic                     start,
    input  logic                     stop,
    output logic [1:0]               wave_choise,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] entry_idx,
    output logic                     seq_done,
    output logic                     err
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [1:0]    MARKER   = 2'b11;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
`ifdef WAVE_SCHED_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [1:0]       tab_choice [DEPTH];
    logic [DUR_W-1:0] tab_dur    [DEPTH];
    logic [DUR_W-1:0] cnt;

    logic [AW-1:0] next_idx;
    logic          entry_end;
    logic          prog_end;
    logic          wr_ok;
    logic          start_ok;
    logic          finish;

    assign next_idx  = entry_idx + 1'b1;
    assign entry_end = (cnt == tab_dur[entry_idx]);
    assign prog_end  = (entry_idx == LAST_IDX) || (tab_choice[next_idx] == MARKER);
    assign wr_ok     = wr_en && (state == IDLE) && !start;
    assign start_ok  = start && (state == IDLE) && (tab_choice[0] != MARKER);

    // A stop seen on an entry's last cycle ends the program just like a DRAIN completion.
    assign finish = entry_end && (
                        (state == DRAIN) ||
                        ((state == RUN) && (stop || (prog_end && !LOOP_EN))));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_choice[i] <= MARKER;
                tab_dur[i]    <= '0;
            end
        end else if (wr_ok) begin
            tab_choice[wr_addr] <= wr_choice;
            tab_dur[wr_addr]    <= wr_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            entry_idx   <= '0;
            wave_choise <= IDLE_CHOICE;
            busy        <= 1'b0;
            seq_done    <= 1'b0;
            err         <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            err      <= (wr_en && !wr_ok) || (start && !start_ok);
            if (finish) begin
                state       <= IDLE;
                cnt         <= '0;
                entry_idx   <= '0;
                wave_choise <= IDLE_CHOICE;
                busy        <= 1'b0;
                seq_done    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state       <= RUN;
                            cnt         <= '0;
                            entry_idx   <= '0;
                            wave_choise <= tab_choice[0];
                            busy        <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (entry_end) begin
                            cnt <= '0;
                            // Only reachable at program end when looping is enabled.
                            if (prog_end) begin
                                entry_idx   <= '0;
                                wave_choise <= tab_choice[0];
                            end else begin
                                entry_idx   <= next_idx;
                                wave_choise <= tab_choice[next_idx];
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (stop) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        cnt <= cnt + 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wave_sched.sv
// tb/tb_wave_sched.sv - randomized and directed bench for wave_sched against a behavioural model
module tb_wave_sched;
    localparam int         DEPTH       = 4;
    localparam int         DUR_W       = 8;
    localparam int         AW          = $clog2(DEPTH);
    localparam logic [1:0] IDLE_CHOICE = 2'b00;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [1:0]       wr_choice;
    logic [DUR_W-1:0] wr_dur;
    logic             start;
    logic             stop;
    logic [1:0]       wave_choise;
    logic             busy;
    logic [AW-1:0]    entry_idx;
    logic             seq_done;
    logic             err;

    wave_sched #(.DEPTH(DEPTH), .DUR_W(DUR_W), .IDLE_CHOICE(IDLE_CHOICE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_choice(wr_choice),
        .wr_dur(wr_dur), .start(start), .stop(stop), .wave_choise(wave_choise),
        .busy(busy), .entry_idx(entry_idx), .seq_done(seq_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: a program is "active" with an entry index and cycles left in that entry.
    int mc [DEPTH];
    int md [DEPTH];
    bit m_active, m_drain, e_done, e_err, chk_en;
    int m_idx, m_left;

    initial chk_en = 1'b0;

    function automatic void m_finish();
        m_active = 0;
        m_drain  = 0;
        m_idx    = 0;
        e_done   = 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mc[i] = 3;
                md[i] = 0;
            end
            m_active = 0; m_drain = 0; m_idx = 0; m_left = 0; e_done = 0; e_err = 0;
        end else begin
            e_done = 0;
            e_err  = 0;
            if (wr_en) begin
                if (!m_active && !start) begin
                    mc[wr_addr] = int'(wr_choice);
                    md[wr_addr] = int'(wr_dur);
                end else begin
                    e_err = 1;
                end
            end
            if (m_active) begin
                if (start) e_err = 1;
                if (m_left == 1) begin
                    if (m_drain || stop) begin
                        m_finish();
                    end else if (m_idx + 1 == DEPTH || mc[m_idx + 1] == 3) begin
`ifdef WAVE_SCHED_LOOP_EN
                        m_idx  = 0;
                        m_left = md[0] + 1;
`else
                        m_finish();
`endif
                    end else begin
                        m_idx  = m_idx + 1;
                        m_left = md[m_idx] + 1;
                    end
                end else begin
                    m_left = m_left - 1;
                    if (stop) m_drain = 1;
                end
            end else if (start) begin
                if (mc[0] == 3) begin
                    e_err = 1;
                end else begin
                    m_active = 1; m_drain = 0; m_idx = 0; m_left = md[0] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_wave", int'(wave_choise), m_active ? mc[m_idx] : int'(IDLE_CHOICE));
            check("model_busy", int'(busy), int'(m_active));
            check("model_idx", int'(entry_idx), m_active ? m_idx : 0);
            check("model_done", int'(seq_done), int'(e_done));
            check("model_err", int'(err), int'(e_err));
        end
    end

    int tw [32];
    int tbz [32];
    int tdn [32];

    task automatic clear_inputs();
        wr_en = 0; start = 0; stop = 0;
        wr_addr = '0; wr_choice = '0; wr_dur = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic wr(input int a, input int c, input int d);
        wr_en = 1; wr_addr = AW'(a); wr_choice = 2'(c); wr_dur = DUR_W'(d);
        @(negedge clk);
        wr_en = 0;
    endtask

    // Caller raises start (if wanted) first; stop is pulsed during cycle index stop_at.
    task automatic run_trace(input int n, input int stop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 0;
            stop  = (i == stop_at);
            tw[i]  = int'(wave_choise);
            tbz[i] = int'(busy);
            tdn[i] = int'(seq_done);
        end
        stop = 0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    int sum_b, sum_d, cnt2, k;

    initial begin
        rst = 1;
        clear_inputs();
        @(negedge clk);
        do_reset();
        chk_en = 1;
        check("rst_wave", int'(wave_choise), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_idx", int'(entry_idx), 0);
        check("rst_done", int'(seq_done), 0);
        check("rst_err", int'(err), 0);

`ifndef WAVE_SCHED_LOOP_EN
        begin
            int exp_sp [10] = '{1, 1, 1, 1, 2, 2, 0, 0, 0, 0};
            int exp_ft [6]  = '{0, 1, 2, 1, 0, 0};
            wr(0, 1, 3); wr(1, 2, 1); wr(2, 3, 0);
            start = 1;
            run_trace(10, -1);
            sum_b = 0; sum_d = 0;
            for (int i = 0; i < 10; i++) begin
                check("single_wave", tw[i], exp_sp[i]);
                sum_b += tbz[i];
                sum_d += tdn[i];
            end
            check("single_busy_cycles", sum_b, 6);
            check("single_done_count", sum_d, 1);
            check("single_done_at6", tdn[6], 1);

            do_reset();
            wr(0, 0, 0); wr(1, 1, 0); wr(2, 2, 0); wr(3, 1, 0);
            start = 1;
            run_trace(6, -1);
            for (int i = 0; i < 6; i++) begin
                check("full_wave", tw[i], exp_ft[i]);
                check("full_busy", tbz[i], (i < 4) ? 1 : 0);
            end
            check("full_done_at4", tdn[4], 1);
        end
`else
        begin
            int exp_lp [10] = '{1, 1, 2, 2, 1, 1, 2, 2, 1, 1};
            wr(0, 1, 1); wr(1, 2, 1);
            start = 1;
            run_trace(13, 8);
            sum_d = 0;
            for (int i = 0; i < 10; i++) begin
                check("loop_wave", tw[i], exp_lp[i]);
                check("loop_busy", tbz[i], 1);
                sum_d += tdn[i];
            end
            check("loop_no_early_done", sum_d, 0);
            check("loop_end_wave", tw[10], 0);
            check("loop_done_at10", tdn[10], 1);
            check("loop_done_once", tdn[11] + tdn[12], 0);
        end
`endif

        // Graceful stop on the 3rd cycle of a 10-cycle entry.
        do_reset();
        wr(0, 2, 9); wr(1, 1, 0);
        start = 1;
        run_trace(13, 2);
        sum_b = 0;
        for (int i = 0; i < 10; i++) check("stop_wave", tw[i], 2);
        for (int i = 0; i < 13; i++) sum_b += tbz[i];
        check("stop_busy_cycles", sum_b, 10);
        check("stop_idle_wave", tw[10], 0);
        check("stop_done_at10", tdn[10], 1);

        // Rejected commands.
        do_reset();
        start = 1;
        @(negedge clk);
        start = 0;
        check("rej_start_marker_err", int'(err), 1);
        check("rej_start_marker_busy", int'(busy), 0);
        wr(0, 1, 5);
        check("rej_good_write_err", int'(err), 0);
        start = 1;
        @(negedge clk);
        start = 0;
        check("rej_run_busy", int'(busy), 1);
        check("rej_run_err", int'(err), 0);
        wr(0, 2, 0);
        check("rej_write_busy_err", int'(err), 1);
        start = 1;
        @(negedge clk);
        start = 0;
        check("rej_start_busy_err", int'(err), 1);
        wait_idle("rej_idle1");
        start = 1;
        @(negedge clk);
        start = 0;
        check("rej_table_unchanged", int'(wave_choise), 1);
        wait_idle("rej_idle2");
        wr_en = 1; wr_addr = 1; wr_choice = 2; wr_dur = 0; start = 1;
        @(negedge clk);
        wr_en = 0; start = 0;
        check("rej_both_busy", int'(busy), 1);
        check("rej_both_err", int'(err), 1);
        cnt2 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wave_choise == 2'b10) cnt2++;
        end
        check("rej_both_write_dropped", cnt2, 0);
        check("rej_both_ended", int'(busy), 0);

        // Reset during entry 1.
        do_reset();
        wr(0, 1, 1); wr(1, 2, 3);
        start = 1;
        @(negedge clk);
        start = 0;
        k = 0;
        while (entry_idx != 1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_reached_entry1", int'(entry_idx), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rstmid_wave", int'(wave_choise), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_idx", int'(entry_idx), 0);
        check("rstmid_done", int'(seq_done), 0);
        start = 1;
        @(negedge clk);
        start = 0;
        check("rstmid_start_err", int'(err), 1);
        check("rstmid_start_busy", int'(busy), 0);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 5000; i++) begin
            rst       = ($urandom % 600) == 0;
            wr_en     = ($urandom % 5) == 0;
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_choice = (($urandom % 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            wr_dur    = (($urandom % 10) == 0) ? DUR_W'($urandom_range(0, 20))
                                                : DUR_W'($urandom_range(0, 3));
            start     = ($urandom % 12) == 0;
            stop      = ($urandom % 20) == 0;
            @(negedge clk);
        end
        rst = 0;
        clear_inputs();
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
